// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types, constants and helper function for the external-interrupt front
// end (irq_controller and irq_sync_edge).
//
// Contents:
//   irq_state_t  - handshake FSM states (IDLE, REQUEST, SERVICE)
//   IRQ_CNT_W    - width of each per-channel service counter (stats build)
//   IRQ_MAX_CH   - largest supported channel count
//   prio_encode  - index of the lowest set bit (fixed priority, bit 0 highest)
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int IRQ_CNT_W  = 16;
    localparam int IRQ_MAX_CH = 32;

    // Returns the index of the lowest set bit; 0 when the vector is empty.
    // Scanning from the top down lets the lowest set bit overwrite the rest.
    function automatic logic [4:0] prio_encode(input logic [IRQ_MAX_CH-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = IRQ_MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One interrupt channel: two-flop synchroniser for an asynchronous request
// line, a previous-value flop, and a single-cycle rising-edge strobe.
//
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - asynchronous active-high reset (all flops cleared)
//   line     - asynchronous request input
//   rise     - one-cycle pulse when the synchronised line goes 0 -> 1
//
// Because prev is cleared by reset, a line that is already high when reset
// releases produces exactly one rise pulse.
// -----------------------------------------------------------------------------
module irq_sync_edge (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic line,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= line;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// External-interrupt front end for the processor core. Synchronises NUM_IRQ
// asynchronous request lines, latches their rising edges as pending, applies a
// per-channel mask and fixed priority (lowest index wins), and drives ExtIRQ
// using a 4-phase ExtIRQ/ExtlAck handshake. The serviced channel index is
// presented zero-extended on irq_cause.
//
// Parameters:
//   N        - width of irq_cause (datapath width)
//   NUM_IRQ  - number of interrupt channels (1..32)
//   CODE_W   - width of the internal channel index
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   irq_in      in   [NUM_IRQ] asynchronous request lines (rising edge)
//   irq_mask    in   [NUM_IRQ] 1 = channel enabled
//   ExtlAck     in   processor acknowledge (level)
//   ExtIRQ      out  interrupt request to processor (registered)
//   irq_cause   out  [N] serviced channel index, zero-extended (registered)
//   irq_pending out  [NUM_IRQ] raw pending bits (registered)
//
// Optional build macro IRQ_STATS_EN adds:
//   irq_count   out  [NUM_IRQ*16] saturating serviced-interrupt count per
//                    channel, channel i at bits [16i+15:16i]
//   irq_lost    out  [NUM_IRQ] sticky flag: edge arrived while already pending
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int N       = 64,
    parameter int NUM_IRQ = 4,
    parameter int CODE_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ExtlAck,
    output logic               ExtIRQ,
    output logic [N-1:0]       irq_cause,
    output logic [NUM_IRQ-1:0] irq_pending
`ifdef IRQ_STATS_EN
    ,
    output logic [NUM_IRQ*IRQ_CNT_W-1:0] irq_count,
    output logic [NUM_IRQ-1:0]           irq_lost
`endif
);

    irq_state_t         state_reg;
    logic               ext_irq_reg;
    logic [CODE_W-1:0]  cause_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] rise_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clear_vec;
    logic [CODE_W-1:0]  winner;
    logic               ack_take;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and edge detector
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            irq_sync_edge u_sync_edge (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .line     (irq_in[gi]),
                .rise     (rise_vec[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    assign eligible = pending_reg & irq_mask;
    assign winner   = CODE_W'(prio_encode(32'(eligible)));

    // The acknowledge is accepted only while a request is outstanding; this
    // is the single point where a pending bit is retired.
    assign ack_take = (state_reg == REQUEST) && ExtlAck;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clear
            assign clear_vec[gi] = ack_take && (cause_reg == CODE_W'(gi));
        end
    endgenerate

    // A new edge on the channel being cleared re-sets it (set wins); an edge
    // on an already-pending channel simply leaves the bit high.
    assign pending_next = (pending_reg & ~clear_vec) | rise_vec;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM. irq_cause is only loaded on IDLE -> REQUEST, so it stays
    // frozen for the whole handshake and holds afterwards for the handler.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ext_irq_reg <= 1'b0;
            cause_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (eligible != '0) begin
                        cause_reg   <= winner;
                        ext_irq_reg <= 1'b1;
                        state_reg   <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (ExtlAck) begin
                        ext_irq_reg <= 1'b0;
                        state_reg   <= SERVICE;
                    end
                end
                SERVICE: begin
                    // Returning through IDLE guarantees at least one quiet
                    // cycle before the next request is raised.
                    if (!ExtlAck) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ext_irq_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign ExtIRQ      = ext_irq_reg;
    assign irq_cause   = N'(cause_reg);
    assign irq_pending = pending_reg;

`ifdef IRQ_STATS_EN
    // ------------------------------------------------------------------
    // Service statistics
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] lost_reg;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_stats
            logic [IRQ_CNT_W-1:0] count_reg;

            // clear_vec marks the REQUEST -> SERVICE transition for this
            // channel; the count sticks at all-ones rather than wrapping.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (clear_vec[gi] && (count_reg != {IRQ_CNT_W{1'b1}})) begin
                    count_reg <= count_reg + IRQ_CNT_W'(1);
                end
            end

            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    lost_reg[gi] <= 1'b0;
                end else if (rise_vec[gi] && pending_reg[gi]) begin
                    lost_reg[gi] <= 1'b1;
                end
            end

            assign irq_count[gi*IRQ_CNT_W +: IRQ_CNT_W] = count_reg;
        end
    endgenerate

    assign irq_lost = lost_reg;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Randomised bench for irq_controller. A stimulus process acts as request
// source and as the processor (drives ExtlAck); a reference model of pending
// bits, mask and priority pushes the expected service order into a queue, and
// a separate monitor pops and compares irq_cause on every ExtIRQ rise.
// -----------------------------------------------------------------------------
module tb_irq_controller;

    localparam int N       = 64;
    localparam int NUM_IRQ = 4;

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               ExtlAck;
    logic               ExtIRQ;
    logic [N-1:0]       irq_cause;
    logic [NUM_IRQ-1:0] irq_pending;
`ifdef IRQ_STATS_EN
    logic [NUM_IRQ*16-1:0] irq_count;
    logic [NUM_IRQ-1:0]    irq_lost;
`endif

    irq_controller #(.N(N), .NUM_IRQ(NUM_IRQ)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .ExtlAck     (ExtlAck),
        .ExtIRQ      (ExtIRQ),
        .irq_cause   (irq_cause),
        .irq_pending (irq_pending)
`ifdef IRQ_STATS_EN
        ,
        .irq_count   (irq_count),
        .irq_lost    (irq_lost)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int                 exp_q[$];
    logic [NUM_IRQ-1:0] m_pending;
    logic [NUM_IRQ-1:0] m_mask;
    logic [NUM_IRQ-1:0] m_lost;
    int                 m_count[NUM_IRQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lowest(input logic [NUM_IRQ-1:0] v);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Expected service order from here on: eligible channels, ascending index.
    task automatic rebuild(input logic [NUM_IRQ-1:0] excl);
        exp_q.delete();
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (m_pending[i] && m_mask[i] && !excl[i]) exp_q.push_back(i);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares irq_cause on each ExtIRQ rising edge
    // ------------------------------------------------------------------
    logic ext_prev = 1'b0;
    int   mon_e;

    always @(negedge CLOCK_50) begin
        if (ExtIRQ === 1'b1 && ext_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_request cause=%0d required=none", irq_cause);
            end else begin
                mon_e = exp_q.pop_front();
                $display("REQ cause=%0d expected=%0d", irq_cause, mon_e);
                check("irq_cause", irq_cause, 64'(mon_e));
            end
        end
        ext_prev <= ExtIRQ;
    end

`ifdef IRQ_STATS_EN
    task automatic check_stats();
        for (int i = 0; i < NUM_IRQ; i++) begin
            check("irq_count", 64'(irq_count[i*16 +: 16]), 64'(m_count[i]));
        end
        check("irq_lost", 64'(irq_lost), 64'(m_lost));
    endtask
`endif

    // ------------------------------------------------------------------
    // Processor side: service every eligible channel. f is pulsed once
    // during the first REQUEST to exercise the frozen cause.
    // ------------------------------------------------------------------
    task automatic serve_all(input logic [NUM_IRQ-1:0] f);
        int c;
        bit got;
        bit first;
        first = 1'b1;
        while ((m_pending & m_mask) != '0) begin
            c   = lowest(m_pending & m_mask);
            got = 1'b0;
            for (int t = 0; t < 20; t++) begin
                tick();
                if (ExtIRQ === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("req_seen", 64'(got), 64'd1);
            if (!got) return;
            repeat ($urandom_range(0, 2)) tick();
            if (first && f != '0) begin
                irq_in    = f;
                m_lost    = m_lost | (f & m_pending);
                m_pending = m_pending | f;
                tick();
                tick();
                irq_in = '0;
                repeat (4) tick();
                rebuild(NUM_IRQ'(1 << c));
                check("cause_frozen", irq_cause, 64'(c));
                check("req_held", 64'(ExtIRQ), 64'd1);
            end
            first   = 1'b0;
            ExtlAck = 1'b1;
            tick();
            m_pending[c] = 1'b0;
            if (m_count[c] < 65535) m_count[c]++;
            check("ext_irq_drop", 64'(ExtIRQ), 64'd0);
            check("pending_clear", 64'(irq_pending), 64'(m_pending));
            repeat ($urandom_range(0, 2)) tick();
            ExtlAck = 1'b0;
            tick();
            check("idle_gap", 64'(ExtIRQ), 64'd0);
        end
    endtask

    // One round: pulse p with everything masked, then open the mask.
    task automatic do_round(input logic [NUM_IRQ-1:0] mask,
                            input logic [NUM_IRQ-1:0] p,
                            input logic [NUM_IRQ-1:0] f);
        irq_mask = '0;
        m_mask   = '0;
        tick();
        irq_in    = p;
        m_lost    = m_lost | (p & m_pending);
        m_pending = m_pending | p;
        repeat ($urandom_range(1, 3)) tick();
        irq_in = '0;
        repeat (4) tick();
        check("pending_masked", 64'(irq_pending), 64'(m_pending));
        check("idle_masked", 64'(ExtIRQ), 64'd0);
        irq_mask = mask;
        m_mask   = mask;
        rebuild('0);
        serve_all(f);
        repeat (5) tick();
        check("quiet", 64'(ExtIRQ), 64'd0);
        check("pending_end", 64'(irq_pending), 64'(m_pending));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef IRQ_STATS_EN
        check_stats();
`endif
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_lost    = '0;
        for (int i = 0; i < NUM_IRQ; i++) m_count[i] = 0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        bit got;
        reset    = 1'b1;
        irq_in   = '0;
        irq_mask = '0;
        ExtlAck  = 1'b0;
        m_mask   = '0;
        model_reset();
        repeat (3) tick();
        check("rst_ext_irq", 64'(ExtIRQ), 64'd0);
        check("rst_cause", irq_cause, 64'd0);
        check("rst_pending", 64'(irq_pending), 64'd0);
        reset = 1'b0;
        tick();

        // Directed scenarios
        do_round(4'hF, 4'b0100, 4'b0000);   // single request on channel 2
        do_round(4'hF, 4'b1010, 4'b0000);   // priority: 1 then 3
        do_round(4'b1110, 4'b0001, 4'b0000); // channel 0 deferred by mask
        do_round(4'hF, 4'b0000, 4'b0000);   // unmask: served with no new edge
        do_round(4'hF, 4'b0100, 4'b0001);   // frozen cause, 0 served next
        do_round(4'b1101, 4'b0010, 4'b0000); // channel 1 pending, masked
        do_round(4'b1101, 4'b0010, 4'b0000); // second edge absorbed (lost)
        do_round(4'hF, 4'b0000, 4'b0000);   // channel 1 served once

        // Randomised rounds
        for (int r = 0; r < 24; r++) begin
            do_round(NUM_IRQ'($urandom), NUM_IRQ'($urandom),
                     ($urandom_range(0, 2) == 0) ? NUM_IRQ'($urandom) : '0);
        end
        do_round(4'hF, 4'b0000, 4'b0000);   // drain anything deferred

        // Reset in the middle of a handshake
        irq_mask = 4'hF;
        m_mask   = 4'hF;
        irq_in   = 4'b0100;
        m_pending = m_pending | 4'b0100;
        rebuild('0);
        tick();
        tick();
        irq_in = '0;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (ExtIRQ === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("req_before_reset", 64'(got), 64'd1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_mid_ext_irq", 64'(ExtIRQ), 64'd0);
        check("rst_mid_pending", 64'(irq_pending), 64'd0);
        check("rst_mid_cause", irq_cause, 64'd0);

        // Line held high across reset release: exactly one request
        irq_in = 4'b0010;
        repeat (3) tick();
        reset     = 1'b0;
        m_pending = 4'b0010;
        rebuild('0);
        serve_all('0);
        repeat (10) tick();
        check("held_line_once", 64'(ExtIRQ), 64'd0);
        check("held_line_pending", 64'(irq_pending), 64'd0);
        check("held_line_queue", 64'(exp_q.size()), 64'd0);
`ifdef IRQ_STATS_EN
        check_stats();
`endif
        irq_in = '0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
